// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Front-end control stage for the stopwatch datapath. Three raw board
// pushbuttons are each synchronised, debounced and edge-detected. The press
// events then drive a run/pause/clear FSM that produces the counter's enable
// and clear controls and the display lap_hold flag.
//
// Ports:
//   clk            - 50 MHz system clock, all logic on the rising edge
//   rst            - asynchronous, active-high reset
//   btn_start_stop - raw start/stop pushbutton (asynchronous)
//   btn_clear      - raw clear pushbutton (asynchronous)
//   btn_lap        - raw lap pushbutton (asynchronous)
//   enable         - count enable, high only in RUNNING
//   clear          - counter clear level, high only in CLEARING
//   lap_hold       - display freeze request for the decoder stage
//   state          - FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 CLEARING
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CLEAR_CYCLES    = 100000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic       enable,
  output logic       clear,
  output logic       lap_hold,
  output logic [1:0] state
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

  // The debouncer accepts the new level on the cycle the count would reach
  // DEBOUNCE_CYCLES, so it compares against one less than that.
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  // Raw level of a button that is not being pushed.
  localparam logic RAW_RELEASED = BTN_ACTIVE_LOW;

  localparam int BTN_SS  = 0;
  localparam int BTN_CLR = 1;
  localparam int BTN_LAP = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUNNING  = 2'b01,
    PAUSED   = 2'b10,
    CLEARING = 2'b11
  } state_t;

  logic [2:0]      raw_btn;
  logic [2:0]      sync_a;
  logic [2:0]      sync_b;
  logic [2:0]      btn_level;
  logic [2:0]      deb_level;
  logic [2:0]      deb_prev;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [3];

  state_t           cur_state;
  logic [CLR_W-1:0] clear_cnt;

  assign raw_btn = {btn_lap, btn_clear, btn_start_stop};

  // Normalised levels are 1 = pressed regardless of board polarity.
  assign btn_level = sync_b ^ {3{RAW_RELEASED}};

  // One-cycle pulse on a debounced released->pressed edge; releases are silent.
  assign press = deb_level & ~deb_prev;

  assign state = cur_state;

  // Two-flop synchroniser. Reset loads the released raw level so a button
  // held through reset deassertion looks like a fresh press afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= {3{RAW_RELEASED}};
      sync_b <= {3{RAW_RELEASED}};
    end else begin
      sync_a <= raw_btn;
      sync_b <= sync_a;
    end
  end

  // Debouncer: any cycle where the synchronised level matches the accepted
  // level wipes the count, so a glitch leaves nothing behind once it ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_level <= '0;
      deb_prev  <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      deb_prev <= deb_level;
      for (int i = 0; i < 3; i++) begin
        if (btn_level[i] != deb_level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb_level[i] <= btn_level[i];
            db_cnt[i]    <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Run/pause/clear FSM. Outputs are registered alongside the state so they
  // change on the same edge. The if/else chains give start_stop priority over
  // clear, and lap only acts when no transition happens in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE;
      enable    <= 1'b0;
      clear     <= 1'b0;
      lap_hold  <= 1'b0;
      clear_cnt <= '0;
    end else begin
      case (cur_state)
        IDLE: begin
          if (press[BTN_SS]) begin
            cur_state <= RUNNING;
            enable    <= 1'b1;
          end else if (press[BTN_CLR]) begin
            cur_state <= CLEARING;
            clear     <= 1'b1;
            clear_cnt <= '0;
            lap_hold  <= 1'b0;
          end
        end
        RUNNING: begin
          if (press[BTN_SS]) begin
            cur_state <= PAUSED;
            enable    <= 1'b0;
          end else if (press[BTN_LAP]) begin
            lap_hold <= ~lap_hold;
          end
        end
        PAUSED: begin
          if (press[BTN_SS]) begin
            cur_state <= RUNNING;
            enable    <= 1'b1;
          end else if (press[BTN_CLR]) begin
            cur_state <= CLEARING;
            clear     <= 1'b1;
            clear_cnt <= '0;
            lap_hold  <= 1'b0;
          end else if (press[BTN_LAP]) begin
            lap_hold <= 1'b0;
          end
        end
        CLEARING: begin
          // clear was raised on entry; drop it after CLEAR_CYCLES cycles.
          if (clear_cnt == CLR_LAST) begin
            cur_state <= IDLE;
            clear     <= 1'b0;
            clear_cnt <= '0;
          end else begin
            clear_cnt <= clear_cnt + CLR_W'(1);
          end
        end
        default: begin
          cur_state <= IDLE;
          enable    <= 1'b0;
          clear     <= 1'b0;
          lap_hold  <= 1'b0;
          clear_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Front-end control stage for the stopwatch datapath. It turns three raw board pushbuttons into the counter's `enable` and `clear` controls and a display `lap_hold` flag. Each button is synchronised, debounced and edge-detected. A small run/pause/clear FSM drives the outputs. The block runs on the 50 MHz board clock and sits directly upstream of the millisecond/second counter and the 7-segment decoders.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a button level change (10 ms at 50 MHz).
CLEAR_CYCLES, 100000, clk cycles `clear` is held high (2 ms, longer than one divided-clock period of the counter).
BTN_ACTIVE_LOW, 1, 1 = buttons read 0 when pressed (board KEYs); 0 = active-high.

Ports:
clk  input  1  50 MHz system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
btn_start_stop  input  1  raw start/stop pushbutton, asynchronous
btn_clear  input  1  raw clear pushbutton, asynchronous
btn_lap  input  1  raw lap pushbutton, asynchronous
enable  output  1  count enable to counter; high only in RUNNING
clear  output  1  counter clear level; high only in CLEARING
lap_hold  output  1  display freeze request for the decoder stage
state  output  2  FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 CLEARING

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; enable=0, clear=0, lap_hold=0.
  - Synchroniser flops, debounced levels and previous levels all = released.
  - All debounce counters and the clear counter = 0.
- Input path per button:
  - Two-flop synchroniser, then normalise polarity via BTN_ACTIVE_LOW.
  - Debouncer: when the synchronised level differs from the debounced level, the counter increments every cycle. It resets to 0 on any cycle where they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - Press event = one-cycle pulse when the debounced level goes released→pressed. Releases generate no event.
- Latency: a raw press held steady produces a state change, and the matching output change, exactly DEBOUNCE_CYCLES+3 clk edges after the first edge that samples it pressed.
- A button held through reset deassertion is treated as a fresh press and produces an event after the normal latency.
- FSM transitions (on press events):
  - IDLE: start_stop→RUNNING; clear→CLEARING; lap ignored.
  - RUNNING: start_stop→PAUSED; clear ignored; lap toggles lap_hold.
  - PAUSED: start_stop→RUNNING; clear→CLEARING; lap forces lap_hold=0.
  - CLEARING: all events ignored. clear=1 for exactly CLEAR_CYCLES cycles, then IDLE.
- lap_hold is forced to 0 on entry to CLEARING.
- Outputs are registered and decoded from state: enable=(state==RUNNING), clear=(state==CLEARING).
- Simultaneous events in one cycle, by priority:
  - start_stop beats clear.
  - Lap is ignored in any cycle where a state transition occurs.
  - Events from different buttons never queue: one FSM action per cycle.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no event, and do not alter counter state beyond that glitch.
- Reset mid-operation (any state, mid-debounce, mid-CLEARING) returns immediately to reset values. No residual clear pulse.

Test Plan (DEBOUNCE_CYCLES=4, CLEAR_CYCLES=3, BTN_ACTIVE_LOW=1):
- Reset, buttons high: state=00, enable=0, clear=0, lap_hold=0. Pull btn_start_stop low and hold → enable=1, state=01 exactly 7 cycles later.
- Glitch and bounce: btn_start_stop low for 3 cycles, then high → no state change. Apply 10 cycles of alternating bounce, then steady low → exactly one RUNNING transition.
- Run → pause → clear: start, release, press start_stop again → PAUSED with enable=0. Press clear → state=11 with clear=1 for exactly 3 cycles, then IDLE.
- Lap: in RUNNING, press lap → lap_hold=1 and enable stays 1. Press lap again → lap_hold=0. Set lap_hold=1, pause, press lap → lap_hold=0.
- Ignored and simultaneous events:
  - Clear while RUNNING → no change.
  - Lap while IDLE → no change.
  - start_stop and clear released-to-pressed on the same cycle in PAUSED → RUNNING, no clear.
- Async reset: assert rst during the 2nd CLEARING cycle, between clock edges → clear=0 and state=00 immediately. Also assert rst mid-debounce → no press event after release of rst.
